// File: rtl/reg_file_param.sv
// Parametrised register file with one write port and two read ports.
// Optional features: write-to-read bypass, registered reads, hardwired-zero r0.
// Each entry has a valid flag that is set by its first write after reset.
// A saturating counter tracks committed writes.
module reg_file_param #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter bit          BYPASS     = 1'b0,
    parameter bit          READ_REG   = 1'b0,
    parameter bit          ZERO_REG   = 1'b0
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [DATA_WIDTH-1:0] IN,
    input  logic [ADDR_WIDTH-1:0] INADDRESS,
    input  logic                  WRITE,
    input  logic [ADDR_WIDTH-1:0] OUT1ADDRESS,
    input  logic [ADDR_WIDTH-1:0] OUT2ADDRESS,
    output logic [DATA_WIDTH-1:0] OUT1,
    output logic [DATA_WIDTH-1:0] OUT2,
    output logic                  OUT1VALID,
    output logic                  OUT2VALID,
    output logic [15:0]           WRITECOUNT
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]      valid_q;
    logic [15:0]           count_q;
    logic                  commit;

    logic [DATA_WIDTH-1:0] rd1_data, rd2_data;
    logic                  rd1_valid, rd2_valid;

    // A write to r0 is dropped entirely when r0 is hardwired to zero.
    assign commit = WRITE && !RESET && !(ZERO_REG && (INADDRESS == '0));

    // Storage array: cleared on reset, updated on committed writes.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (commit) begin
            mem_q[INADDRESS] <= IN;
        end
    end

    // Valid flags: r0 counts as written from reset when it is hardwired to zero.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid_q    <= '0;
            valid_q[0] <= ZERO_REG;
        end else if (commit) begin
            valid_q[INADDRESS] <= 1'b1;
        end
    end

    // Saturating count of committed writes.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            count_q <= '0;
        end else if (commit && (count_q != 16'hFFFF)) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign WRITECOUNT = count_q;

    // Read data per port; the zero-register override wins over bypass.
    always_comb begin
        rd1_data  = mem_q[OUT1ADDRESS];
        rd1_valid = valid_q[OUT1ADDRESS];
        if (BYPASS && commit && (INADDRESS == OUT1ADDRESS)) begin
            rd1_data  = IN;
            rd1_valid = 1'b1;
        end
        if (ZERO_REG && (OUT1ADDRESS == '0)) begin
            rd1_data  = '0;
            rd1_valid = 1'b1;
        end

        rd2_data  = mem_q[OUT2ADDRESS];
        rd2_valid = valid_q[OUT2ADDRESS];
        if (BYPASS && commit && (INADDRESS == OUT2ADDRESS)) begin
            rd2_data  = IN;
            rd2_valid = 1'b1;
        end
        if (ZERO_REG && (OUT2ADDRESS == '0)) begin
            rd2_data  = '0;
            rd2_valid = 1'b1;
        end
    end

    if (READ_REG) begin : gen_read_reg
        // Registered reads: capture the pre-edge read value, cleared by reset.
        always_ff @(posedge CLK) begin
            if (RESET) begin
                OUT1      <= '0;
                OUT2      <= '0;
                OUT1VALID <= 1'b0;
                OUT2VALID <= 1'b0;
            end else begin
                OUT1      <= rd1_data;
                OUT2      <= rd2_data;
                OUT1VALID <= rd1_valid;
                OUT2VALID <= rd2_valid;
            end
        end
    end else begin : gen_read_comb
        assign OUT1      = rd1_data;
        assign OUT2      = rd2_data;
        assign OUT1VALID = rd1_valid;
        assign OUT2VALID = rd2_valid;
    end

endmodule

// File: doc/reg_file_param.md
# reg_file_param

Parametrised successor to the CPU's 8×8 register file: a DEPTH×DATA_WIDTH register array with one write port and two read ports, adding optional write-to-read bypass, optional registered (pipelined) reads, an optional hardwired-zero register 0, per-entry "written since reset" valid flags and a saturating committed-write counter. It sits between the instruction decoder/ALU result path and the ALU operand inputs of the CPU datapath. With default parameters it is a drop-in replacement for the existing register file.

## Interface
- DATA_WIDTH, 8, bits per register
- ADDR_WIDTH, 3, address bits; DEPTH = 2**ADDR_WIDTH registers
- BYPASS, 0, 1 = a read of the address being written this cycle returns IN
- READ_REG, 0, 1 = read outputs registered at posedge CLK (1-cycle latency); 0 = combinational reads
- ZERO_REG, 0, 1 = register 0 reads as zero and ignores writes
- CLK  input  1  clock; all state changes on posedge
- RESET  input  1  synchronous, active-high reset, sampled on posedge CLK
- IN  input  DATA_WIDTH  write data
- INADDRESS  input  ADDR_WIDTH  write address
- WRITE  input  1  write enable
- OUT1ADDRESS  input  ADDR_WIDTH  read port 1 address
- OUT2ADDRESS  input  ADDR_WIDTH  read port 2 address
- OUT1  output  DATA_WIDTH  read port 1 data
- OUT2  output  DATA_WIDTH  read port 2 data
- OUT1VALID  output  1  addressed entry written since last reset (port 1)
- OUT2VALID  output  1  addressed entry written since last reset (port 2)
- WRITECOUNT  output  16  committed writes since reset, saturating

## Operation
- Reset (RESET=1 at posedge): every entry cleared to 0; all valid flags cleared, except entry 0, which is set when ZERO_REG=1; WRITECOUNT set to 0; with READ_REG=1, OUT1/OUT2/OUT1VALID/OUT2VALID registers cleared to 0. RESET overrides WRITE.
- Committed write: WRITE=1, RESET=0 at posedge, and not (ZERO_REG=1 and INADDRESS=0). On a committed write:
  - entry[INADDRESS] <= IN
  - valid[INADDRESS] <= 1
  - WRITECOUNT increments, holding at 16'hFFFF once reached
- Discarded write to register 0 under ZERO_REG=1: array, valid flags and WRITECOUNT are unchanged.
- Read value per port = stored entry, with the following overrides:
  - BYPASS=1 and a committed write is pending this cycle to the same address: IN, with valid=1
  - ZERO_REG=1 and address 0: 0, with valid=1, regardless of bypass
- READ_REG=0: OUTn/OUTnVALID follow the read value combinationally.
- READ_REG=1: at each posedge, OUTn/OUTnVALID register the read value computed from the pre-edge state and the inputs at that edge. The address applied at edge k therefore appears after edge k; with BYPASS=1 it includes the data being written at edge k.
- Both ports may address the same entry; both return identical data.
- Out-of-range addresses are impossible (DEPTH = 2**ADDR_WIDTH).

## Timing
- Write latency: data visible in the array after the committed posedge. Without bypass, a same-cycle read returns the old value.
- Combinational reads (READ_REG=0): OUTn change #2 after any address, array or (with BYPASS) IN/WRITE/INADDRESS change.
- Registered reads (READ_REG=1): OUTn change #2 after posedge; 1-cycle address-to-data latency; outputs are 0 for the cycle following a reset edge.
- Reset output values:
  - WRITECOUNT=0
  - READ_REG=1: OUT1=OUT2=0, OUT1VALID=OUT2VALID=0
  - READ_REG=0: OUTn=0, OUTnVALID=0, except address 0 with ZERO_REG=1, where OUTnVALID=1
- Reset asserted mid-operation: any write at that edge is lost; no partial update.

## Test plan
- Defaults: reset, write 8'h11→r0, 8'h88→r1, read r0/r1 → OUT1=8'h11, OUT2=8'h88 #2 after address change, VALID=1/1, WRITECOUNT=2; r2 reads 0 with VALID=0.
- BYPASS=1, READ_REG=0: WRITE=1, INADDRESS=3, IN=8'hA5, OUT1ADDRESS=3 before edge → OUT1=8'hA5 pre-edge; same with BYPASS=0 → OUT1=8'h00 until after edge.
- READ_REG=1, BYPASS=1: address r3 at edge k while writing 8'h5A to r3 → OUT1=8'h5A after edge k; change address at edge k+1 → new data only after edge k+1.
- ZERO_REG=1: write 8'hFF→r0 → OUT1=0, OUT1VALID=1, WRITECOUNT unchanged; write r7 → WRITECOUNT+1.
- Reset with WRITE=1, IN=8'h77→r4 at same edge → r4=0, valid[4]=0, WRITECOUNT=0.
- DATA_WIDTH=16, ADDR_WIDTH=4: write 16'hBEEF→r15, read on both ports → both 16'hBEEF; 70000 writes → WRITECOUNT=16'hFFFF.
